// File: rtl/fetch_hazard_ctrl.sv
// Fetch-side pipeline controller: owns the PC, resolves load-use stalls,
// taken-branch redirects and debug halt/single-step, and counts stall cycles.
module fetch_hazard_ctrl #(
  parameter int unsigned INSTMEM_LOG2_DEEP = 8,
  parameter int unsigned RESET_PC          = 0,
  parameter int unsigned LOAD_LAT          = 1
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         idex_memread,
  input  logic [4:0]                   idex_rd,
  input  logic [4:0]                   ifid_rs1,
  input  logic [4:0]                   ifid_rs2,
  input  logic                         ifid_use_rs2,
  input  logic                         br_taken,
  input  logic [INSTMEM_LOG2_DEEP-1:0] br_target,
  input  logic                         halt_req,
  input  logic                         step,
  output logic [INSTMEM_LOG2_DEEP-1:0] pc,
  output logic                         hazard,
  output logic                         ifid_flush,
  output logic                         idex_bubble,
  output logic                         halted,
  output logic [15:0]                  stall_count
);

  localparam int unsigned PCW = INSTMEM_LOG2_DEEP;
  localparam logic [PCW-1:0] RESET_PC_V = PCW'(RESET_PC);
  // First STALL-state count; the detection cycle itself is the first stall cycle.
  localparam logic [2:0] STALL_INIT = (LOAD_LAT > 1) ? 3'(LOAD_LAT - 2) : 3'd0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [2:0]     cnt, cnt_nxt;
  logic [PCW-1:0] pc_nxt;
  logic           lu;
  logic           hazard_c, flush_c, bubble_c;

  assign lu = idex_memread && (idex_rd != 5'd0) &&
              ((idex_rd == ifid_rs1) || (ifid_use_rs2 && (idex_rd == ifid_rs2)));

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pc_nxt    = pc;
    hazard_c  = 1'b0;
    flush_c   = 1'b0;
    bubble_c  = 1'b0;

    if (br_taken) begin
      // Redirect outranks everything and aborts any stall in progress.
      pc_nxt    = br_target;
      flush_c   = 1'b1;
      bubble_c  = 1'b1;
      cnt_nxt   = 3'd0;
      state_nxt = halt_req ? HALT : RUN;
    end else begin
      unique case (state)
        RUN: begin
          if (lu) begin
            hazard_c = 1'b1;
            bubble_c = 1'b1;
            if (LOAD_LAT > 1) begin
              state_nxt = STALL;
              cnt_nxt   = STALL_INIT;
            end
          end else begin
            pc_nxt = pc + 1'b1;
            if (halt_req) state_nxt = HALT;
          end
        end
        STALL: begin
          hazard_c = 1'b1;
          bubble_c = 1'b1;
          if (cnt == 3'd0) state_nxt = RUN;
          else             cnt_nxt   = cnt - 3'd1;
        end
        HALT: begin
          if (step && !lu) begin
            pc_nxt = pc + 1'b1;
          end else begin
            hazard_c = 1'b1;
            bubble_c = 1'b1;
          end
          if (!halt_req) state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // Strobes are silenced for the whole time reset is held, not just at an edge.
  assign hazard      = RST && hazard_c;
  assign ifid_flush  = RST && flush_c;
  assign idex_bubble = RST && bubble_c;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= RUN;
      cnt         <= 3'd0;
      pc          <= RESET_PC_V;
      halted      <= 1'b0;
      stall_count <= 16'd0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      pc     <= pc_nxt;
      halted <= (state_nxt == HALT);
      if (hazard_c && (stall_count != 16'hFFFF)) stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Scoreboard bench for fetch_hazard_ctrl (N=8, RESET_PC=0, LOAD_LAT=3):
// per-cycle vectors are queued with their expected results, then replayed.
module tb_fetch_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       idex_memread;
  logic [4:0] idex_rd, ifid_rs1, ifid_rs2;
  logic       ifid_use_rs2, br_taken, halt_req, step;
  logic [7:0] br_target, pc;
  logic       hazard, ifid_flush, idex_bubble, halted;
  logic [15:0] stall_count;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_sc;

  typedef struct {
    string      name;
    logic       memread;
    logic [4:0] rd, rs1, rs2;
    logic       use2, br;
    logic [7:0] tgt;
    logic       hreq, stp;
    logic       hz, fl, bb;
    logic [7:0] pc;
    logic       hl;
  } vec_t;

  vec_t sb[$];

  fetch_hazard_ctrl #(
    .INSTMEM_LOG2_DEEP(8),
    .RESET_PC(0),
    .LOAD_LAT(3)
  ) dut (
    .CLK(CLK), .RST(RST),
    .idex_memread(idex_memread), .idex_rd(idex_rd),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_use_rs2(ifid_use_rs2),
    .br_taken(br_taken), .br_target(br_target),
    .halt_req(halt_req), .step(step),
    .pc(pc), .hazard(hazard), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .halted(halted), .stall_count(stall_count)
  );

  always #5 CLK = ~CLK;

  // lu_in=1 produces a rs1 load-use match (rd=5, rs1=5).
  function automatic vec_t mk(input string name, input logic lu_in, input logic br,
                              input logic [7:0] tgt, input logic hreq, input logic stp,
                              input logic hz, input logic fl, input logic bb,
                              input logic [7:0] epc, input logic hl);
    vec_t v;
    v.name = name;  v.memread = lu_in; v.rd = lu_in ? 5'd5 : 5'd0;
    v.rs1 = lu_in ? 5'd5 : 5'd0; v.rs2 = 5'd0; v.use2 = 1'b0;
    v.br = br; v.tgt = tgt; v.hreq = hreq; v.stp = stp;
    v.hz = hz; v.fl = fl; v.bb = bb; v.pc = epc; v.hl = hl;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    idex_memread = v.memread; idex_rd = v.rd; ifid_rs1 = v.rs1; ifid_rs2 = v.rs2;
    ifid_use_rs2 = v.use2; br_taken = v.br; br_target = v.tgt;
    halt_req = v.hreq; step = v.stp;
  endtask

  task automatic clear_inputs();
    vec_t v;
    v = mk("idle", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    drive(v);
  endtask

  task automatic test_reset();
    RST = 1'b0;
    clear_inputs();
    idex_memread = 1'b1; idex_rd = 5'd5; ifid_rs1 = 5'd5;  // lu true, must be masked
    halt_req = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      checks++;
      if ({pc, hazard, ifid_flush, idex_bubble, halted, stall_count} !== {8'h00, 4'b0000, 16'h0000}) begin
        errors++;
        $display("FAIL reset: pc=%h hz=%b fl=%b bb=%b hl=%b sc=%h want pc=00 all 0",
                 pc, hazard, ifid_flush, idex_bubble, halted, stall_count);
      end
    end
    clear_inputs();
    exp_sc = 16'h0000;
    RST = 1'b1;
  endtask

  task automatic test_free_run();
    logic [7:0] epc;
    epc = 8'h00;
    for (int i = 0; i < 260; i++) begin
      epc = epc + 8'd1;
      sb.push_back(mk("free_run", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, epc, 1'b0));
    end
    while (sb.size() > 0) begin
      vec_t v;
      v = sb.pop_front();
      drive(v);
      #1;
      checks++;
      if ({hazard, ifid_flush, idex_bubble} !== {v.hz, v.fl, v.bb}) begin
        errors++;
        $display("FAIL %s strobes got %b%b%b want %b%b%b", v.name, hazard, ifid_flush, idex_bubble, v.hz, v.fl, v.bb);
      end
      @(posedge CLK); #1;
      checks++;
      if (pc !== v.pc || halted !== v.hl || stall_count !== exp_sc) begin
        errors++;
        $display("FAIL %s pc=%h hl=%b sc=%h want pc=%h hl=%b sc=%h", v.name, pc, halted, stall_count, v.pc, v.hl, exp_sc);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_load_use();
    vec_t v;
    sb.push_back(mk("lu_redirect", 1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h10, 1'b0));
    sb.push_back(mk("lu_detect",   1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 1'b0));
    sb.push_back(mk("lu_stall2",   1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 1'b0));
    sb.push_back(mk("lu_stall3",   1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 1'b0));
    sb.push_back(mk("lu_release",  1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0));
    v = mk("lu_rd_zero", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h12, 1'b0);
    v.rd = 5'd0; v.rs1 = 5'd0;
    sb.push_back(v);
    v = mk("lu_rs2_unused", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h13, 1'b0);
    v.rd = 5'd7; v.rs1 = 5'd3; v.rs2 = 5'd7; v.use2 = 1'b0;
    sb.push_back(v);
    v.name = "lu_rs2_used"; v.use2 = 1'b1; v.hz = 1'b1; v.bb = 1'b1;
    sb.push_back(v);
    sb.push_back(mk("lu_rs2_stall2", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h13, 1'b0));
    sb.push_back(mk("lu_rs2_stall3", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h13, 1'b0));
    sb.push_back(mk("lu_rs2_release", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h14, 1'b0));
    while (sb.size() > 0) begin
      v = sb.pop_front();
      drive(v);
      #1;
      checks++;
      if ({hazard, ifid_flush, idex_bubble} !== {v.hz, v.fl, v.bb}) begin
        errors++;
        $display("FAIL %s strobes got %b%b%b want %b%b%b", v.name, hazard, ifid_flush, idex_bubble, v.hz, v.fl, v.bb);
      end
      if (v.hz) exp_sc = exp_sc + 16'd1;
      @(posedge CLK); #1;
      checks++;
      if (pc !== v.pc || halted !== v.hl || stall_count !== exp_sc) begin
        errors++;
        $display("FAIL %s pc=%h hl=%b sc=%h want pc=%h hl=%b sc=%h", v.name, pc, halted, stall_count, v.pc, v.hl, exp_sc);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_branch_in_stall();
    vec_t v;
    sb.push_back(mk("bis_detect",  1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h14, 1'b0));
    sb.push_back(mk("bis_branch",  1'b0, 1'b1, 8'h40, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h40, 1'b0));
    sb.push_back(mk("bis_run",     1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h41, 1'b0));
    sb.push_back(mk("bis_run2",    1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h42, 1'b0));
    while (sb.size() > 0) begin
      v = sb.pop_front();
      drive(v);
      #1;
      checks++;
      if ({hazard, ifid_flush, idex_bubble} !== {v.hz, v.fl, v.bb}) begin
        errors++;
        $display("FAIL %s strobes got %b%b%b want %b%b%b", v.name, hazard, ifid_flush, idex_bubble, v.hz, v.fl, v.bb);
      end
      if (v.hz) exp_sc = exp_sc + 16'd1;
      @(posedge CLK); #1;
      checks++;
      if (pc !== v.pc || halted !== v.hl || stall_count !== exp_sc) begin
        errors++;
        $display("FAIL %s pc=%h hl=%b sc=%h want pc=%h hl=%b sc=%h", v.name, pc, halted, stall_count, v.pc, v.hl, exp_sc);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_halt_step();
    vec_t v;
    sb.push_back(mk("hs_redirect", 1'b0, 1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h20, 1'b0));
    sb.push_back(mk("hs_halt",     1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h21, 1'b1));
    sb.push_back(mk("hs_hold",     1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h21, 1'b1));
    for (int i = 0; i < 3; i++) begin
      sb.push_back(mk("hs_step", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h22 + i), 1'b1));
      sb.push_back(mk("hs_gap",  1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'(8'h22 + i), 1'b1));
    end
    sb.push_back(mk("hs_step_lu",  1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h24, 1'b1));
    sb.push_back(mk("hs_release",  1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h24, 1'b0));
    sb.push_back(mk("hs_resume",   1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h25, 1'b0));
    while (sb.size() > 0) begin
      v = sb.pop_front();
      drive(v);
      #1;
      checks++;
      if ({hazard, ifid_flush, idex_bubble} !== {v.hz, v.fl, v.bb}) begin
        errors++;
        $display("FAIL %s strobes got %b%b%b want %b%b%b", v.name, hazard, ifid_flush, idex_bubble, v.hz, v.fl, v.bb);
      end
      if (v.hz) exp_sc = exp_sc + 16'd1;
      @(posedge CLK); #1;
      checks++;
      if (pc !== v.pc || halted !== v.hl || stall_count !== exp_sc) begin
        errors++;
        $display("FAIL %s pc=%h hl=%b sc=%h want pc=%h hl=%b sc=%h", v.name, pc, halted, stall_count, v.pc, v.hl, exp_sc);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_simultaneous();
    vec_t v;
    sb.push_back(mk("sim_all",     1'b1, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h80, 1'b1));
    sb.push_back(mk("sim_hold",    1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h80, 1'b1));
    sb.push_back(mk("sim_br_halt", 1'b0, 1'b1, 8'h90, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h90, 1'b0));
    sb.push_back(mk("sim_run",     1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h91, 1'b0));
    while (sb.size() > 0) begin
      v = sb.pop_front();
      drive(v);
      #1;
      checks++;
      if ({hazard, ifid_flush, idex_bubble} !== {v.hz, v.fl, v.bb}) begin
        errors++;
        $display("FAIL %s strobes got %b%b%b want %b%b%b", v.name, hazard, ifid_flush, idex_bubble, v.hz, v.fl, v.bb);
      end
      if (v.hz) exp_sc = exp_sc + 16'd1;
      @(posedge CLK); #1;
      checks++;
      if (pc !== v.pc || halted !== v.hl || stall_count !== exp_sc) begin
        errors++;
        $display("FAIL %s pc=%h hl=%b sc=%h want pc=%h hl=%b sc=%h", v.name, pc, halted, stall_count, v.pc, v.hl, exp_sc);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_saturation_async_reset();
    int total;
    idex_memread = 1'b1; idex_rd = 5'd9; ifid_rs1 = 5'd9;
    repeat (70000) @(negedge CLK);
    total = int'(exp_sc) + 70000;
    exp_sc = (total > 65535) ? 16'hFFFF : 16'(total);
    #1;
    checks++;
    if (stall_count !== exp_sc || hazard !== 1'b1) begin
      errors++;
      $display("FAIL saturate sc=%h hz=%b want sc=%h hz=1", stall_count, hazard, exp_sc);
    end
    clear_inputs();
    halt_req = 1'b1;
    repeat (4) @(negedge CLK);
    #1;
    checks++;
    if (halted !== 1'b1 || hazard !== 1'b1 || stall_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL enter_halt hl=%b hz=%b sc=%h want hl=1 hz=1 sc=ffff", halted, hazard, stall_count);
    end
    #1 RST = 1'b0;
    #1;
    checks++;
    if ({pc, hazard, ifid_flush, idex_bubble, halted, stall_count} !== {8'h00, 4'b0000, 16'h0000}) begin
      errors++;
      $display("FAIL async_reset pc=%h hz=%b fl=%b bb=%b hl=%b sc=%h want all 0",
               pc, hazard, ifid_flush, idex_bubble, halted, stall_count);
    end
    @(negedge CLK);
    clear_inputs();
    RST = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if (pc !== 8'h01 || halted !== 1'b0 || hazard !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_run pc=%h hl=%b hz=%b want pc=01 hl=0 hz=0", pc, halted, hazard);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_load_use();
    test_branch_in_stall();
    test_halt_step();
    test_simultaneous();
    test_saturation_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
